// File: rtl/mult24465_seq_ctrl.sv
// mult24465_seq_ctrl: sequential x*24465 using one shared add/sub, one shift-add term per clock.
// Define MULT24465_SEQ_PIPE_ACCEPT_EN to accept the next operand in the same cycle a product is consumed.
module mult24465_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data0,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_data0,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_busy
);
  localparam int NTERMS = 5;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, out_q, out_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       shamt;
  logic [WIDTH-1:0] term;
  logic             sub, last, accept;
  always_comb begin
    shamt = idx_q == 3'd1 ? 4'd15 : idx_q == 3'd2 ? 4'd13 : idx_q == 3'd3 ? 4'd4 : idx_q == 3'd4 ? 4'd7 : 4'd0;
    sub = idx_q == 3'd2 || idx_q == 3'd4;
    term = x_q << shamt;
    last = idx_q == 3'(NTERMS - 1);
`ifdef MULT24465_SEQ_PIPE_ACCEPT_EN
    i_ready = state_q == IDLE || (state_q == DONE && o_ready);
`else
    i_ready = state_q == IDLE;
`endif
    o_valid = state_q == DONE;
    o_busy = state_q != IDLE;
    o_data0 = out_q;
    accept = i_valid && i_ready;
    state_d = state_q;
    acc_d = acc_q;
    x_d = x_q;
    idx_d = idx_q;
    out_d = out_q;
    if (state_q == ACCUM) begin
      acc_d = sub ? acc_q - term : acc_q + term;
      idx_d = idx_q + 3'd1;
      if (last) begin
        state_d = DONE;
        out_d = acc_d;
      end
    end else if (state_q == DONE && o_ready) begin
      state_d = IDLE;
    end
    // Accept overrides the DONE->IDLE hop so a pipelined operand goes straight to ACCUM.
    if (accept) begin
      x_d = i_data0;
      acc_d = '0;
      idx_d = '0;
      state_d = ACCUM;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      x_q <= '0;
      idx_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      x_q <= x_d;
      idx_q <= idx_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_mult24465_seq_ctrl.sv
// tb_mult24465_seq_ctrl: scoreboard bench for the sequential x*24465 controller.
module tb_mult24465_seq_ctrl;
  logic        clk = 0, rst = 1;
  logic [31:0] i_data0 = 0, o_data0;
  logic        i_valid = 0, i_ready, o_valid, o_ready = 1, o_busy;
  int          tests = 0, fails = 0;
  logic [31:0] sb[$];

  mult24465_seq_ctrl dut (
    .clk(clk), .rst(rst), .i_data0(i_data0), .i_valid(i_valid), .i_ready(i_ready),
    .o_data0(o_data0), .o_valid(o_valid), .o_ready(o_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] x);
    return x * 32'd24465;
  endfunction

  task automatic do_op(input logic [31:0] x, input bit chk_lat);
    int n, cnt;
    logic [31:0] exp;
    @(negedge clk);
    i_data0 = x;
    i_valid = 1;
    n = 0;
    while (!i_ready && n < 20) begin @(negedge clk); n++; end
    sb.push_back(model(x));
    @(posedge clk); #1;
    i_valid = 0;
    i_data0 = $urandom;
    cnt = 0;
    while (!o_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    exp = sb.size() > 0 ? sb.pop_front() : 32'hDEADBEEF;
    if (chk_lat) begin
      tests++;
      if (cnt !== 5) begin fails++; $display("FAIL latency x=%h got %0d cycles want 5", x, cnt); end
    end
    tests++;
    if (o_valid !== 1'b1 || o_data0 !== exp) begin
      fails++;
      $display("FAIL product x=%h got %h (valid %b) want %h", x, o_data0, o_valid, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if (o_valid !== 0 || o_data0 !== 0 || o_busy !== 0 || i_ready !== 1) begin
      fails++;
      $display("FAIL reset got v=%b d=%h b=%b r=%b want 0 0 0 1", o_valid, o_data0, o_busy, i_ready);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_basic;
    do_op(32'd1, 1);
    do_op(32'd0, 1);
    do_op(32'hFFFFFFFF, 0);
    do_op(32'h00010000, 0);
    do_op(32'h80000000, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) do_op($urandom, 0);
  endtask

  task automatic test_stall;
    int n;
    logic [31:0] exp;
    o_ready = 0;
    @(negedge clk);
    i_data0 = 32'h00001234;
    i_valid = 1;
    n = 0;
    while (!i_ready && n < 20) begin @(negedge clk); n++; end
    sb.push_back(model(32'h00001234));
    @(posedge clk); #1;
    i_data0 = 32'hA5A5A5A5;
    n = 0;
    while (!o_valid && n < 20) begin @(posedge clk); #1; n++; end
    exp = sb.size() > 0 ? sb.pop_front() : 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (o_valid !== 1 || o_data0 !== exp || i_ready !== 0) begin
        fails++;
        $display("FAIL stall%0d got v=%b d=%h r=%b want 1 %h 0", k, o_valid, o_data0, i_ready, exp);
      end
      @(posedge clk); #1;
    end
    i_valid = 0;
    o_ready = 1;
    @(posedge clk); #1;
    tests++;
    if (o_valid !== 0 || o_busy !== 0 || o_data0 !== exp) begin
      fails++;
      $display("FAIL stall_release got v=%b b=%b d=%h want 0 0 %h", o_valid, o_busy, o_data0, exp);
    end
    @(posedge clk); #1;
    tests++;
    if (o_busy !== 0) begin fails++; $display("FAIL ignored_ivalid got busy=%b want 0", o_busy); end
  endtask

  task automatic test_reset_mid;
    int bad;
    @(negedge clk);
    i_data0 = 32'd5;
    i_valid = 1;
    @(posedge clk); #1;
    i_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    tests++;
    if (o_valid !== 0 || i_ready !== 1 || o_busy !== 0) begin
      fails++;
      $display("FAIL reset_mid got v=%b r=%b b=%b want 0 1 0", o_valid, i_ready, o_busy);
    end
    @(negedge clk); rst = 0;
    bad = 0;
    repeat (8) begin @(posedge clk); #1; if (o_valid !== 0) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset_mid_pulse got %0d valid cycles want 0", bad); end
    do_op(32'd7, 1);
  endtask

  task automatic test_back_to_back;
    int cyc, n_sent, n_rcv, spacing;
    int t[3];
    bit acc;
    logic [31:0] exp;
`ifdef MULT24465_SEQ_PIPE_ACCEPT_EN
    spacing = 6;
`else
    spacing = 7;
`endif
    cyc = 0; n_sent = 0; n_rcv = 0;
    o_ready = 1;
    @(negedge clk);
    i_data0 = 32'd1;
    i_valid = 1;
    while (n_rcv < 3 && cyc < 60) begin
      if (o_valid) begin
        exp = sb.size() > 0 ? sb.pop_front() : 32'hDEADBEEF;
        tests++;
        if (o_data0 !== exp) begin fails++; $display("FAIL b2b%0d got %h want %h", n_rcv, o_data0, exp); end
        t[n_rcv] = cyc;
        n_rcv++;
      end
      acc = i_valid && i_ready;
      if (acc) sb.push_back(model(i_data0));
      @(posedge clk); #1;
      if (acc) begin
        n_sent++;
        if (n_sent < 3) i_data0 = n_sent + 1;
        else i_valid = 0;
      end
      @(negedge clk);
      cyc++;
    end
    i_valid = 0;
    tests++;
    if (n_rcv != 3) begin
      fails++;
      $display("FAIL b2b_count got %0d results want 3", n_rcv);
    end else begin
      tests++;
      if (t[1] - t[0] != spacing || t[2] - t[1] != spacing) begin
        fails++;
        $display("FAIL b2b_spacing got %0d,%0d want %0d", t[1] - t[0], t[2] - t[1], spacing);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
